dlx_pipe_cu: RTL

- Pipelined hardwired control unit for the DLX-style datapath (register file, ALU, data memory, write-back mux).
- Accepts one decoded instruction (opcode/func) per cycle and emits the 13-signal control word, split across four stages so each datapath stage sees the controls of the instruction it currently holds.
- Handles hazard stalls and a data-memory wait handshake.

---
 rtl/dlx_pipe_cu.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dlx_pipe_cu.sv
// Pipelined hardwired control unit for a DLX-style datapath: decodes opcode/func and
// staggers the 13-bit control word over four stages. Optional DLX_PIPE_CU_PERF_EN adds counters.
module dlx_pipe_cu #(
    parameter int OP_CODE_SIZE = 6,
    parameter int FUNC_SIZE    = 11,
    parameter int CW_SIZE      = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_CODE_SIZE-1:0] opcode,
    input  logic [FUNC_SIZE-1:0]    func,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    stall,
    input  logic                    mem_ready,
    output logic                    rf1,
    output logic                    rf2,
    output logic                    en1,
    output logic                    s1,
    output logic                    s2,
    output logic                    alu1,
    output logic                    alu2,
    output logic                    en2,
    output logic                    rm,
    output logic                    wm,
    output logic                    en3,
    output logic                    s3,
    output logic                    wf1,
`ifdef DLX_PIPE_CU_PERF_EN
    output logic [31:0]             retired_cnt,
    output logic [31:0]             stall_cnt,
`endif
    output logic                    illegal
);

    generate
        if (CW_SIZE != 13) begin : g_bad_cw_size
            $error("dlx_pipe_cu: CW_SIZE must be 13");
        end
    endgenerate

    localparam logic [OP_CODE_SIZE-1:0] OP_RTYPE = OP_CODE_SIZE'(6'h00);
    localparam logic [OP_CODE_SIZE-1:0] OP_ADDI  = OP_CODE_SIZE'(6'h08);
    localparam logic [OP_CODE_SIZE-1:0] OP_NOP   = OP_CODE_SIZE'(6'h15);
    localparam logic [OP_CODE_SIZE-1:0] OP_LW    = OP_CODE_SIZE'(6'h23);
    localparam logic [OP_CODE_SIZE-1:0] OP_SW    = OP_CODE_SIZE'(6'h2B);
    localparam logic [FUNC_SIZE-1:0]    FN_ADD   = FUNC_SIZE'(11'h020);
    localparam logic [FUNC_SIZE-1:0]    FN_SUB   = FUNC_SIZE'(11'h022);
    localparam logic [FUNC_SIZE-1:0]    FN_AND   = FUNC_SIZE'(11'h024);
    localparam logic [FUNC_SIZE-1:0]    FN_OR    = FUNC_SIZE'(11'h025);

    // Word layout: rf1 rf2 en1 | s1 s2 alu1 alu2 en2 | rm wm en3 | s3 wf1
    localparam logic [12:0] CW_RTYPE = 13'b111_10001_001_01;
    localparam logic [12:0] CW_ADDI  = 13'b101_11001_001_01;
    localparam logic [12:0] CW_LW    = 13'b101_11001_101_11;
    localparam logic [12:0] CW_SW    = 13'b111_11001_010_00;

    // Each stage keeps only the bits that it or later stages still need.
    logic [12:0] st1_reg, st1_next;
    logic [9:0]  st2_reg, st2_next;
    logic [4:0]  st3_reg, st3_next;
    logic [1:0]  st4_reg, st4_next;
    logic [3:1]  valid_reg, valid_next;
    logic        illegal_reg;

    logic [12:0] dec_cw;
    logic        dec_legal;
    logic        mem_freeze;
    logic        accept;

    always_comb begin
        dec_cw    = '0;
        dec_legal = 1'b0;
        if (opcode == OP_RTYPE) begin
            dec_legal = 1'b1;
            case (func)
                FN_ADD:  dec_cw = CW_RTYPE;
                FN_SUB:  dec_cw = CW_RTYPE | 13'b000_00010_000_00;
                FN_AND:  dec_cw = CW_RTYPE | 13'b000_00100_000_00;
                FN_OR:   dec_cw = CW_RTYPE | 13'b000_00110_000_00;
                default: dec_legal = 1'b0;
            endcase
        end else if (opcode == OP_ADDI) begin
            dec_legal = 1'b1;
            dec_cw    = CW_ADDI;
        end else if (opcode == OP_LW) begin
            dec_legal = 1'b1;
            dec_cw    = CW_LW;
        end else if (opcode == OP_SW) begin
            dec_legal = 1'b1;
            dec_cw    = CW_SW;
        end else if (opcode == OP_NOP) begin
            dec_legal = 1'b1;
        end
    end

    assign mem_freeze = valid_reg[3] && (st3_reg[4] || st3_reg[3]) && !mem_ready;
    assign in_ready   = !rst && !mem_freeze && !stall;
    assign accept     = in_valid && in_ready;

    always_comb begin
        st1_next   = st1_reg;
        st2_next   = st2_reg;
        st3_next   = st3_reg;
        st4_next   = st4_reg;
        valid_next = valid_reg;
        if (mem_freeze) begin
            st4_next = '0;
        end else if (stall) begin
            st4_next      = st3_reg[1:0];
            st3_next      = st2_reg[4:0];
            st2_next      = '0;
            valid_next[3] = valid_reg[2];
            valid_next[2] = 1'b0;
        end else begin
            st4_next      = st3_reg[1:0];
            st3_next      = st2_reg[4:0];
            st2_next      = st1_reg[9:0];
            valid_next[3] = valid_reg[2];
            valid_next[2] = valid_reg[1];
            // Illegal instructions enter as a bubble.
            st1_next      = (accept && dec_legal) ? dec_cw : '0;
            valid_next[1] = accept && dec_legal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st1_reg     <= '0;
            st2_reg     <= '0;
            st3_reg     <= '0;
            st4_reg     <= '0;
            valid_reg   <= '0;
            illegal_reg <= 1'b0;
        end else begin
            st1_reg     <= st1_next;
            st2_reg     <= st2_next;
            st3_reg     <= st3_next;
            st4_reg     <= st4_next;
            valid_reg   <= valid_next;
            // Set only on the acceptance edge, so it can never repeat while a stage is frozen.
            illegal_reg <= accept && !dec_legal;
        end
    end

`ifdef DLX_PIPE_CU_PERF_EN
    logic        valid4_reg;
    logic [31:0] retired_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid4_reg      <= 1'b0;
            retired_cnt_reg <= '0;
            stall_cnt_reg   <= '0;
        end else begin
            valid4_reg      <= mem_freeze ? 1'b0 : valid_reg[3];
            // Stage 4 is replaced every cycle, so a valid occupant always retires.
            retired_cnt_reg <= retired_cnt_reg + {31'd0, valid4_reg};
            stall_cnt_reg   <= stall_cnt_reg + {31'd0, !in_ready};
        end
    end

    assign retired_cnt = retired_cnt_reg;
    assign stall_cnt   = stall_cnt_reg;
`endif

    assign rf1     = st1_reg[12];
    assign rf2     = st1_reg[11];
    assign en1     = st1_reg[10];
    assign s1      = st2_reg[9];
    assign s2      = st2_reg[8];
    assign alu1    = st2_reg[7];
    assign alu2    = st2_reg[6];
    assign en2     = st2_reg[5];
    assign rm      = st3_reg[4];
    assign wm      = st3_reg[3];
    assign en3     = st3_reg[2];
    assign s3      = st4_reg[1];
    assign wf1     = st4_reg[0];
    assign illegal = illegal_reg;

endmodule
